imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, registered immediate generator for the decode stage. It takes a full
//  32-bit RV instruction, classifies it (R/I/S/B/U/J, shift-imm, illegal), and sign-extends
//  the immediate to XLEN. The result is buffered in a 2-entry valid/ready register slice
//  between fetch and execute, so decode absorbs backpressure without a combinational ready path.
// PARAMETERS
//  XLEN    32   datapath width of imm_o; legal values are 32 and 64.
//  SHAMT_W 5    shift-amount width for SLLI/SRLI/SRAI; 5 when XLEN=32, 6 when XLEN=64.
// PORTS
//  clk_i      in   1     single clock; every flop is on the rising edge.
//  rst_n_i    in   1     asynchronous, active-low reset.
//  flush_i    in   1     synchronous flush of all buffered entries.
//  valid_i    in   1     upstream instruction valid.
//  ready_o    out  1     slice can accept; driven only by a flop (no valid_i->ready_o path).
//  instr_i    in   32    raw instruction word.
//  valid_o    out  1     imm_o/fmt_o/illegal_o valid.
//  ready_i    in   1     downstream accepts.
//  imm_o      out  XLEN  extended immediate.
//  fmt_o      out  3     format code: R=0, I=1, S=2, B=3, U=4, J=5, SHIFT=6, NONE=7.
//  illegal_o  out  1     opcode not recognised.
// BEHAVIOUR
//  Reset: valid_o=0, imm_o=0, fmt_o=NONE, illegal_o=0, occupancy=0, ready_o=1.
//  Decode (opcode=instr[6:0], s=instr[31]), all sign-extended from s to XLEN:
//   I 0000011/0010011/1100111/1110011: {s.., instr[31:20]}
//   SHIFT 0010011 with funct3 001/101: zero-extended instr[20+SHAMT_W-1:20]; funct7 bits are masked out.
//   S 0100011: {s.., instr[31:25], instr[11:7]}
//   B 1100011: {s.., instr[7], instr[30:25], instr[11:8], 1'b0}
//   U 0110111/0010111: {s.., instr[31:12], 12'b0}
//   J 1101111: {s.., instr[19:12], instr[20], instr[30:21], 1'b0}
//   R 0110011: imm=0.
//   Any other opcode: imm=0, fmt=NONE, illegal=1.
//  Handshake:
//   - Transfer occurs when valid && ready on the same edge.
//   - Latency is 1 cycle: a word accepted at edge N appears at valid_o after edge N.
//   - Once valid_o is high, it and its data stay stable until ready_i is seen.
//  Occupancy FSM (EMPTY, ONE, TWO; main + skid registers):
//   EMPTY: on accept -> ONE (main loaded).
//   ONE: accept without pop -> TWO (skid loaded). Pop without accept -> EMPTY.
//     Accept and pop together -> ONE (main reloaded).
//   TWO: ready_o=0. On pop, skid moves to main -> ONE. Input is never taken in TWO.
//   ready_o = (state != TWO), registered.
//  Ordering is strict FIFO. No entry is ever dropped or duplicated except by flush or reset.
//  Flush has priority over every other event in the same cycle:
//   - Next state is EMPTY, valid_o=0, ready_o=1.
//   - The concurrent input is discarded.
//   - Output data registers may keep stale values.
//  Reset asserted mid-transfer clears all state at once. Pending entries are lost.
//  Decode arithmetic is pure bit selection and replication; nothing can overflow.
// STRUCTURE
//  Shared package riscv_pkg:
//   - opcode constants (OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH,
//     OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP);
//   - FMT_* codes;
//   - occupancy state encodings.
//  Sub-module imm_decode (combinational: instr -> imm, fmt, illegal; XLEN/SHAMT_W params).
//  imm_gen_pipe holds the main/skid registers and the occupancy FSM.
// TESTING
//  1. 0xFFF00093 (addi -1) -> imm_o=0xFFFFFFFF, fmt=I, valid_o one cycle after accept.
//     0x4030D093 (srai 3) -> imm_o=0x00000003, fmt=SHIFT.
//  2. 0xFE112E23 (sw -4) -> 0xFFFFFFFC, fmt=S.
//     0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt=B.
//  3. 0x123450B7 (lui) -> 0x12345000, fmt=U.
//     0x0010006F (jal +2048) -> 0x00000800, fmt=J.
//     0x0000007F -> illegal_o=1, imm_o=0.
//  4. Backpressure: ready_i=0, three back-to-back valid_i.
//     -> two accepted, ready_o=0, third held upstream.
//     Then ready_i=1 -> all three emerge in order with no gaps or loss.
//  5. Flush in state TWO with valid_i=1 -> next cycle valid_o=0, ready_o=1, new word not emitted.
//     Reset pulse mid-stream -> all outputs return to reset values asynchronously.
//  6. XLEN=64: 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
//     0x03F09093 (slli 63) -> 0x000000000000003F.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV decode constants: major opcodes, immediate format codes and
// the occupancy encoding of the decode-stage register slice.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHIFT = 3'd6;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction classifier and immediate extractor; zero latency,
// no handshake (pure function of instr).
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        s;
  logic [31:0] raw;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign s      = instr[31];

  always_comb begin
    raw     = '0;
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        raw = {{20{s}}, instr[31:20]};
        imm = XLEN'($signed(raw));
        fmt = FMT_I;
      end
      OPC_OPIMM: begin
        // Shift-immediates carry funct7 in the upper bits; only shamt survives.
        if (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI) begin
          imm = XLEN'(instr[20 +: SHAMT_W]);
          fmt = FMT_SHIFT;
        end else begin
          raw = {{20{s}}, instr[31:20]};
          imm = XLEN'($signed(raw));
          fmt = FMT_I;
        end
      end
      OPC_STORE: begin
        raw = {{20{s}}, instr[31:25], instr[11:7]};
        imm = XLEN'($signed(raw));
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        raw = {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm = XLEN'($signed(raw));
        fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        raw = {instr[31:12], 12'b0};
        imm = XLEN'($signed(raw));
        fmt = FMT_U;
      end
      OPC_JAL: begin
        raw = {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm = XLEN'($signed(raw));
        fmt = FMT_J;
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: 1-cycle latency through a 2-entry main/skid slice;
// ready_o comes straight from a flop and drops only when both entries are full.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  occ_e            occ_q, occ_d;
  logic            rdy_q;
  logic            accept, pop;
  logic            load_main_dec, load_main_skid, load_skid;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  logic [XLEN-1:0] main_imm_q, skid_imm_q;
  logic [2:0]      main_fmt_q, skid_fmt_q;
  logic            main_ill_q, skid_ill_q;

  imm_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .instr   (instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign accept = valid_i & rdy_q;
  assign pop    = (occ_q != OCC_EMPTY) & ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_q <= OCC_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      occ_q <= occ_d;
      rdy_q <= (occ_d != OCC_TWO);
    end
  end

  // Flush wins over everything; data registers are left stale on flush.
  always_comb begin
    occ_d          = occ_q;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d         = OCC_ONE;
            load_main_dec = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && !pop) begin
            occ_d     = OCC_TWO;
            load_skid = 1'b1;
          end else if (pop && !accept) begin
            occ_d = OCC_EMPTY;
          end else if (pop && accept) begin
            load_main_dec = 1'b1;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            occ_d          = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      main_ill_q <= 1'b0;
    end else if (load_main_dec) begin
      main_imm_q <= dec_imm;
      main_fmt_q <= dec_fmt;
      main_ill_q <= dec_ill;
    end else if (load_main_skid) begin
      main_imm_q <= skid_imm_q;
      main_fmt_q <= skid_fmt_q;
      main_ill_q <= skid_ill_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
      skid_ill_q <= 1'b0;
    end else if (load_skid) begin
      skid_imm_q <= dec_imm;
      skid_fmt_q <= dec_fmt;
      skid_ill_q <= dec_ill;
    end
  end

  assign ready_o   = rdy_q;
  assign valid_o   = (occ_q != OCC_EMPTY);
  assign imm_o     = main_imm_q;
  assign fmt_o     = main_fmt_q;
  assign illegal_o = main_ill_q;

endmodule
